maze_walker_dp: RTL

Parametrised datapath for the maze-solver walker. It holds the current (x, y) cell, computes the candidate neighbour for a 2-bit direction, flags grid edges, and keeps a DEPTH-entry LIFO of visited cells for backtracking. It sits under the solver controller, which issues step/back/done commands, and can optionally stream the final path out through a ready/valid port.

---
 rtl/maze_walker_dp.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/maze_walker_dp.sv
// Maze-walker datapath: current cell, neighbour/edge logic, visited-cell LIFO.
// Define MAZE_PATH_READOUT_EN to stream the final path out on the path_* port.
module maze_walker_dp #(
  parameter int CW    = 4,
  parameter int DEPTH = 16,
  parameter int SPW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          back,
  input  logic          done,
  input  logic [1:0]    dir,
  output logic [CW-1:0] cur_x,
  output logic [CW-1:0] cur_y,
  output logic [CW-1:0] nxt_x,
  output logic [CW-1:0] nxt_y,
  output logic          edge_hit,
  output logic          stk_empty,
  output logic          stk_full,
  output logic [SPW-1:0] stk_cnt,
  output logic          ovf_err,
  output logic          unf_err,
  output logic          frozen,
  output logic          path_valid,
  output logic          path_last,
  input  logic          path_ready,
  output logic [CW-1:0] path_x,
  output logic [CW-1:0] path_y
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {WALK, DUMP, HOLD} state_t;
  state_t state_q, state_d;

  logic [2*CW-1:0] stk [DEPTH];
  logic [SPW-1:0]  cnt;
  logic            axis_x, inc;
  logic [CW-1:0]   sel, mv;
  logic            push, pop, set_ovf, set_unf;

  // Odd-parity directions move along x; dir[0] selects increment.
  assign axis_x   = dir[1] ^ dir[0];
  assign inc      = dir[0];
  assign sel      = axis_x ? cur_x : cur_y;
  assign mv       = inc ? sel + 1'b1 : sel - 1'b1;
  assign nxt_x    = axis_x ? mv : cur_x;
  assign nxt_y    = axis_x ? cur_y : mv;
  assign edge_hit = inc ? (sel == {CW{1'b1}}) : (sel == '0);

  assign stk_cnt   = cnt;
  assign stk_empty = (cnt == '0);
  assign stk_full  = (cnt == SPW'(DEPTH));
  assign frozen    = (state_q != WALK);

`ifdef MAZE_PATH_READOUT_EN
  logic [SPW-1:0] rd_idx;
  logic           rd_cur;
  logic [2*CW-1:0] rd_ent;

  // Beats 0..cnt-1 come from the stack, beat cnt is the frozen current cell.
  assign rd_cur     = (rd_idx == cnt);
  assign rd_ent     = stk[AW'(rd_idx)];
  assign path_valid = (state_q == DUMP);
  assign path_last  = path_valid && rd_cur;
  assign path_x     = !path_valid ? '0 : rd_cur ? cur_x : rd_ent[2*CW-1:CW];
  assign path_y     = !path_valid ? '0 : rd_cur ? cur_y : rd_ent[CW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             rd_idx <= '0;
    else if (path_valid && path_ready)    rd_idx <= rd_idx + 1'b1;
  end
`else
  logic unused_rdy;
  assign unused_rdy = path_ready;
  assign path_valid = 1'b0;
  assign path_last  = 1'b0;
  assign path_x     = '0;
  assign path_y     = '0;
`endif

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (state_q)
      WALK: begin
        if (done) begin
`ifdef MAZE_PATH_READOUT_EN
          state_d = DUMP;
`else
          state_d = HOLD;
`endif
        end else if (back) begin
          if (!stk_empty) pop     = 1'b1;
          else            set_unf = 1'b1;
        end else if (step && !edge_hit) begin
          if (stk_full) set_ovf = 1'b1;
          else          push    = 1'b1;
        end
      end
      DUMP: begin
`ifdef MAZE_PATH_READOUT_EN
        if (path_last && path_ready) state_d = HOLD;
`else
        state_d = HOLD;
`endif
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WALK;
      cur_x   <= '0;
      cur_y   <= '0;
      cnt     <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_ovf) ovf_err <= 1'b1;
      if (set_unf) unf_err <= 1'b1;
      if (push) begin
        cur_x <= nxt_x;
        cur_y <= nxt_y;
        cnt   <= cnt + 1'b1;
      end else if (pop) begin
        {cur_x, cur_y} <= stk[AW'(cnt - 1'b1)];
        cnt            <= cnt - 1'b1;
      end
    end
  end

  // Storage needs no reset: only entries below cnt are ever read.
  always_ff @(posedge clk) begin
    if (push) stk[AW'(cnt)] <= {cur_x, cur_y};
  end
endmodule
